// File: rtl/mw_add_seq_if.sv
// Request/response bundle for the multi-word add/subtract sequencer.
// The master drives operands and accepts results; the slave is the sequencer.
interface mw_add_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = 16 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/mw_add_seq.sv
// Multi-word add/subtract sequencer: one 16-bit ripple-carry slice per cycle,
// least significant first, with the inter-slice carry kept in a register.

module rca16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_ci,
  output logic [15:0] o_s,
  output logic        o_co
);
  logic w_carry;

  always_comb begin
    w_carry = i_ci;
    o_s     = '0;
    for (int k = 0; k < 16; k++) begin
      o_s[k]  = i_a[k] ^ i_b[k] ^ w_carry;
      w_carry = (i_a[k] & i_b[k]) | (w_carry & (i_a[k] ^ i_b[k]));
    end
    o_co = w_carry;
  end
endmodule

// state  | meaning
// IDLE   | waiting for an operand request, in_ready high
// RUN    | one 16-bit slice per cycle, carry chained through r_carry
// DONE   | result valid, held until the consumer takes it
module mw_add_seq #(
  parameter int WORDS = 4
) (
  input  logic          clk,
  input  logic          rst,
  mw_add_seq_if.slave   bus
);
  localparam int W  = 16 * WORDS;
  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic          r_carry;
  logic          r_cout;
  logic          r_ovf;
  logic [IW-1:0] r_idx;

  logic [15:0]   w_a_slice;
  logic [15:0]   w_b_slice;
  logic [15:0]   w_slice_sum;
  logic          w_slice_co;
  logic          w_last;

  assign w_a_slice = r_a[16*r_idx +: 16];
  assign w_b_slice = r_b[16*r_idx +: 16];
  assign w_last    = (r_idx == IW'(WORDS - 1));

  rca16 u_rca (
    .i_a  (w_a_slice),
    .i_b  (w_b_slice),
    .i_ci (r_carry),
    .o_s  (w_slice_sum),
    .o_co (w_slice_co)
  );

  // r_b holds the effective operand (already inverted for subtract), so the
  // sub flag itself need not be kept past acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub | bus.cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[16*r_idx +: 16] <= w_slice_sum;
          r_carry               <= w_slice_co;
          if (w_last) begin
            r_cout  <= w_slice_co;
            r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_slice_sum[15] != r_a[W-1]);
            r_idx   <= '0;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE) && !rst;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_mw_add_seq.sv
// Self-checking bench for mw_add_seq (WORDS=4): vector table, scoreboard
// queue filled at acceptance, plus backpressure, reset-abort and back-to-back runs.
module tb_mw_add_seq;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mw_add_seq_if #(.WORDS(WORDS)) bus ();
  mw_add_seq #(.WORDS(WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  vec_t vecs[10];
  exp_t exp_q[$];
  exp_t cur_exp;
  int   checks = 0, errors = 0;
  int   cyc = 0, acc_count = 0, done_count = 0, last_acc_edge = 0;
  bit   have_prev = 0, b2b_mode = 0, prev_ov = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Handshakes are predicted at the negedge for the following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_ov   = 0;
      have_prev = 0;
    end else begin
      if (bus.busy) chk("in_ready_low_while_busy", bus.in_ready, 0);
      if (bus.out_valid && !prev_ov) chk("latency", cyc - last_acc_edge, WORDS);
      if (bus.in_valid && bus.in_ready) begin
        if (b2b_mode && have_prev) chk("initiation_interval", cyc + 1 - last_acc_edge, WORDS + 2);
        last_acc_edge = cyc + 1;
        have_prev     = 1;
        exp_q.push_back(cur_exp);
        acc_count++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got sum %h with no pending request", bus.sum);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result{cout,ovf,sum}", {bus.cout, bus.ovf, bus.sum}, {e.co, e.ov, e.s});
        end
        done_count++;
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic drive_op(input int k, input bit hold);
    int  start;
    bit  ok;
    @(posedge clk); #1;
    bus.a        = vecs[k].a;
    bus.b        = vecs[k].b;
    bus.sub      = vecs[k].sub;
    bus.cin      = vecs[k].cin;
    cur_exp      = '{vecs[k].s, vecs[k].co, vecs[k].ov};
    bus.in_valid = 1'b1;
    start = acc_count;
    ok    = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (acc_count != start) begin
        ok = 1;
        break;
      end
    end
    if (!hold) bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout vec %0d: no accept within 50 cycles", k);
    end
  endtask

  task automatic wait_done(input int n);
    int start;
    bit ok;
    start = done_count;
    ok    = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done_count - start >= n) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: got %0d results, expected %0d", done_count - start, n);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int tbl[9];
    int acc_before, dstart;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[3] = '{64'h0, 64'h1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[4] = '{64'h1234, 64'h1, 1'b0, 1'b1, 64'h1236, 1'b0, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[6] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[7] = '{64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b1, 1'b0};
    vecs[8] = '{64'h0001_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0001_0001_0000_0000, 1'b0, 1'b0};
    vecs[9] = '{64'h1_0000, 64'h1, 1'b1, 1'b0, 64'hFFFF, 1'b1, 1'b0};
    tbl = '{0, 1, 2, 3, 4, 5, 6, 7, 9};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.cin       = 1'b0;
    cur_exp       = '{64'h0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_result", {bus.cout, bus.ovf, bus.sum}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1);

    foreach (tbl[i]) begin
      drive_op(tbl[i], 0);
      wait_done(1);
    end

    // backpressure: result must hold while in_valid and operands wiggle
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive_op(7, 0);
    acc_before = acc_count;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    chk("bp_out_valid_seen", bus.out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.in_valid = i[0];
      bus.a        = {$urandom, $urandom};
      bus.b        = {$urandom, $urandom};
      bus.sub      = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_hold_result", {bus.cout, bus.ovf, bus.sum}, {vecs[7].co, vecs[7].ov, vecs[7].s});
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
    end
    chk("bp_no_extra_accept", acc_count - acc_before, 0);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    dstart        = done_count;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_single_handshake", done_count - dstart, 1);
    chk("bp_idle_busy", bus.busy, 0);
    chk("bp_idle_in_ready", bus.in_ready, 1);

    // reset asserted in the second RUN cycle aborts the operation
    drive_op(9, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_sum", bus.sum, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", bus.in_ready, 1);
    drive_op(8, 0);
    wait_done(1);

    // back-to-back with in_valid held high
    @(posedge clk); #1;
    have_prev = 0;
    b2b_mode  = 1;
    dstart    = done_count;
    drive_op(1, 1);
    drive_op(2, 1);
    drive_op(3, 1);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done_count - dstart >= 3) break;
    end
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("b2b_result_count", done_count - dstart, 3);
    chk("b2b_queue_empty", exp_q.size(), 0);
    b2b_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
